// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 2;
   localparam int LEN_W          = 8 * LEN_BYTES;

   // States in which the loader is willing to take a stream byte.
   function automatic logic rx_state(loader_state_t s);
      return s inside {LEN_HI, LEN_LO, DATA, CHECK};
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 32
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imu_wen;
   logic [ADDR_W-1:0] imu_addr;
   logic [WORD_W-1:0] imu_data;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, imu_wen, imu_addr, imu_data
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, imu_wen, imu_addr, imu_data
   );
endinterface

// File: rtl/loader_word_packer.sv
// Packs an MSB-first byte stream into instruction words.
module loader_word_packer
   import loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        clr,
   input  logic                        flush,
   input  logic                        shift_en,
   input  logic [7:0]                  byte_in,
   output logic                        word_full,
   output logic [8*BYTES_PER_WORD-1:0] word
);
   localparam int CNT_W  = $clog2(BYTES_PER_WORD);
   localparam int HOLD_W = 8 * (BYTES_PER_WORD - 1);

   logic [CNT_W-1:0]  cnt;
   logic [HOLD_W-1:0] held;

   // The last byte of a word is never stored here: the word is presented
   // with the incoming byte appended so the writer can capture it on the same edge.
   assign word_full = shift_en && (cnt == CNT_W'(BYTES_PER_WORD - 1));
   assign word      = {held, byte_in};

   always_ff @(posedge clk) begin
      if (clr || flush) begin
         cnt  <= '0;
         held <= '0;
      end else if (shift_en) begin
         cnt  <= cnt + CNT_W'(1);
         held <= {held[HOLD_W-9:0], byte_in};
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory, core held in clear meanwhile.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   program_loader_if.master bus,
   output logic             cpu_hold,
   output logic             done,
   output logic             error
);
   localparam int DEPTH = 2 ** ADDR_W;

   loader_state_t     state, nxt;
   logic [7:0]        len_hi;
   logic [LEN_W-1:0]  n_words;
   logic              len_ok;
   logic [ADDR_W:0]   words_left;
   logic              accept, start_ok, shift_en, word_full, last_word;
   logic [WORD_W-1:0] packed_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign accept    = bus.byte_valid && bus.byte_ready;
   assign start_ok  = start && (state inside {IDLE, DONE, ERR});
   assign shift_en  = accept && (state == DATA);
   assign n_words   = {len_hi, bus.byte_data};
   assign len_ok    = (n_words != '0) && (32'(n_words) <= 32'(DEPTH));
   assign last_word = (words_left == (ADDR_W+1)'(1));

   loader_word_packer u_packer (
      .clk       (clk),
      .clr       (clr),
      .flush     (start_ok),
      .shift_en  (shift_en),
      .byte_in   (bus.byte_data),
      .word_full (word_full),
      .word      (packed_word)
   );

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:        if (start_ok) nxt = LEN_HI;
         LEN_HI:      if (accept) nxt = LEN_LO;
         LEN_LO:      if (accept) nxt = len_ok ? DATA : ERR;
         DATA:        if (word_full) nxt = WRITE;
`ifdef LOADER_CHECKSUM_EN
         WRITE:       nxt = last_word ? CHECK : DATA;
         CHECK:       if (accept) nxt = (bus.byte_data == csum) ? DONE : ERR;
`else
         WRITE:       nxt = last_word ? DONE : DATA;
         CHECK:       nxt = ERR;  // unreachable without the checksum feature
`endif
         DONE, ERR:   if (start_ok) nxt = LEN_HI;
         default:     nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (clr) begin
         state          <= IDLE;
         bus.byte_ready <= 1'b0;
         bus.imu_wen    <= 1'b0;
         bus.imu_addr   <= '0;
         bus.imu_data   <= '0;
         cpu_hold       <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         len_hi         <= '0;
         words_left     <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum           <= '0;
`endif
      end else begin
         state          <= nxt;
         bus.byte_ready <= rx_state(nxt);
         bus.imu_wen    <= (nxt == WRITE);
         cpu_hold       <= !(nxt inside {IDLE, DONE});
         done           <= (nxt == DONE);
         error          <= (nxt == ERR);

         if (start_ok) begin
            bus.imu_addr <= '0;
            words_left   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
         end
         if (accept && state == LEN_HI) len_hi <= bus.byte_data;
         if (accept && state == LEN_LO) words_left <= n_words[ADDR_W:0];
         if (word_full) bus.imu_data <= packed_word;
`ifdef LOADER_CHECKSUM_EN
         if (shift_en) csum <= csum ^ bus.byte_data;
`endif
         // Address stops on the final word so a full-depth image never wraps.
         if (state == WRITE) begin
            words_left <= words_left - (ADDR_W+1)'(1);
            if (!last_word) bus.imu_addr <= bus.imu_addr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of loads against a stream-level model, plus corner sequences.
module tb_program_loader;

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];
   typedef struct {
      logic [15:0] n;
      bit          spec;
      int          gap;
      bit          exp_ok;
   } vec_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   logic start = 1'b0;
   logic cpu_hold, done, error;

   program_loader_if #(.ADDR_W(8), .WORD_W(32)) bus();

   program_loader #(.ADDR_W(8), .WORD_W(32)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Write-port monitor; everything it collects is judged by the main sequence.
   logic [7:0]  got_addr[$];
   logic [31:0] got_data[$];
   int          wen_long = 0;
   int          ready_viol = 0;
   logic        wen_d = 1'b0;

   always @(negedge clk) begin
      if (bus.imu_wen) begin
         got_addr.push_back(bus.imu_addr);
         got_data.push_back(bus.imu_data);
         if (bus.byte_ready) ready_viol++;
         if (wen_d) wen_long++;
      end
      wen_d = bus.imu_wen;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: stream bytes and the words memory must receive.
   task automatic build(input logic [15:0] n, input bit spec, input bit bad_cs,
                        output bq_t s, output wq_t ew);
      logic [31:0] spec_words [2];
      logic [31:0] w;
      logic [7:0]  cs;
      spec_words[0] = 32'h20080005;
      spec_words[1] = 32'h8C090000;
      s = {};
      ew = {};
      cs = 8'h00;
      s.push_back(n[15:8]);
      s.push_back(n[7:0]);
      if (n >= 16'd1 && n <= 16'd256) begin
         for (int i = 0; i < int'(n); i++) begin
            w = spec ? spec_words[i % 2] : $urandom;
            ew.push_back(w);
            for (int b = 3; b >= 0; b--) begin
               s.push_back(w[8*b +: 8]);
               cs = cs ^ w[8*b +: 8];
            end
         end
`ifdef LOADER_CHECKSUM_EN
         s.push_back(bad_cs ? (cs ^ 8'h01) : cs);
`endif
      end
   endtask

   task automatic send(input bq_t s, input int gap);
      int budget;
      foreach (s[i]) begin
         for (int g = 0; g < 3 && $urandom_range(0, 99) < gap; g++) begin
            bus.byte_valid = 1'b0;
            @(negedge clk);
         end
         bus.byte_valid = 1'b1;
         bus.byte_data  = s[i];
         budget = 0;
         while (!bus.byte_ready && budget < 50) begin
            @(negedge clk);
            budget++;
         end
         if (!bus.byte_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte %0d never accepted, byte_ready=0 required 1", i);
            bus.byte_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input bq_t s, input int gap,
                           input bit exp_ok, input wq_t ew);
      int base = got_addr.size();
      int wl   = wen_long;
      int rv   = ready_viol;
      int nw;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " hold_after_start"}, 32'(cpu_hold), 32'd1);
      chk({tag, " done_cleared"}, 32'(done), 32'd0);
      chk({tag, " error_cleared"}, 32'(error), 32'd0);
      send(s, gap);
      for (int c = 0; c < 20 && !(done || error); c++) @(negedge clk);
      if (!(done || error)) begin
         checks++;
         errors++;
         $display("FAIL %s end_timeout: done=0 error=0, required one of them", tag);
      end
      chk({tag, " done"}, 32'(done), 32'(exp_ok));
      chk({tag, " error"}, 32'(error), 32'(!exp_ok));
      chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'(!exp_ok));
      nw = got_addr.size() - base;
      chk({tag, " num_writes"}, 32'(nw), 32'(ew.size()));
      for (int i = 0; i < ew.size() && i < nw; i++) begin
         chk($sformatf("%s addr[%0d]", tag, i), 32'(got_addr[base+i]), 32'(i));
         chk($sformatf("%s data[%0d]", tag, i), got_data[base+i], ew[i]);
      end
      chk({tag, " wen_one_cycle"}, 32'(wen_long - wl), 32'd0);
      chk({tag, " ready_low_in_write"}, 32'(ready_viol - rv), 32'd0);
   endtask

   vec_t tbl [8];
   bq_t  s;
   wq_t  ew;

   initial begin
      tbl[0] = '{16'd2,     1'b1, 0,  1'b1};
      tbl[1] = '{16'd2,     1'b1, 60, 1'b1};
      tbl[2] = '{16'd0,     1'b0, 0,  1'b0};
      tbl[3] = '{16'd257,   1'b0, 0,  1'b0};
      tbl[4] = '{16'd1,     1'b0, 20, 1'b1};
      tbl[5] = '{16'hFFFF,  1'b0, 0,  1'b0};
      tbl[6] = '{16'd7,     1'b0, 40, 1'b1};
      tbl[7] = '{16'd256,   1'b0, 10, 1'b1};

      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("rst imu_wen", 32'(bus.imu_wen), 32'd0);
      chk("rst imu_addr", 32'(bus.imu_addr), 32'd0);
      chk("rst imu_data", bus.imu_data, 32'd0);
      chk("rst cpu_hold", 32'(cpu_hold), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst error", 32'(error), 32'd0);
      clr = 1'b0;
      @(negedge clk);
      chk("idle byte_ready", 32'(bus.byte_ready), 32'd0);

      foreach (tbl[i]) begin
         build(tbl[i].n, tbl[i].spec, 1'b0, s, ew);
         run_load($sformatf("vec%0d", i), s, tbl[i].gap, tbl[i].exp_ok, ew);
      end

      // Reset after the second byte of the first word: partial word dropped.
      begin
         int base;
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         base = got_addr.size();
         s = '{8'h00, 8'h02, 8'h20, 8'h08};
         send(s, 0);
         clr = 1'b1;
         @(negedge clk);
         chk("midclr byte_ready", 32'(bus.byte_ready), 32'd0);
         chk("midclr imu_wen", 32'(bus.imu_wen), 32'd0);
         chk("midclr imu_addr", 32'(bus.imu_addr), 32'd0);
         chk("midclr imu_data", bus.imu_data, 32'd0);
         chk("midclr cpu_hold", 32'(cpu_hold), 32'd0);
         chk("midclr done", 32'(done), 32'd0);
         chk("midclr error", 32'(error), 32'd0);
         clr = 1'b0;
         repeat (2) @(negedge clk);
         chk("midclr no_write", 32'(got_addr.size() - base), 32'd0);
         build(16'd3, 1'b0, 1'b0, s, ew);
         run_load("after_clr", s, 0, 1'b1, ew);
      end

`ifdef LOADER_CHECKSUM_EN
      build(16'd2, 1'b1, 1'b1, s, ew);
      run_load("bad_csum", s, 0, 1'b0, ew);
      build(16'd2, 1'b1, 1'b0, s, ew);
      run_load("good_csum", s, 0, 1'b1, ew);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
